// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK excitation driver and its excitation logic.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE,
        DONE
    } state_e;

    localparam int EXC_SR     = 0;
    localparam int EXC_TOGGLE = 1;

    localparam int ERR_CNT_W  = 8;
    localparam int SETTLE_W   = 4;  // holds SETTLE_CYC-1 for SETTLE_CYC up to 15
    localparam int RETRY_W    = 3;  // holds MAX_RETRY up to 7

endpackage

// File: rtl/jk_excite.sv
// Combinational J/K excitation: derives the inputs that move a JK bank from q to d.
module jk_excite
    import jk_drv_pkg::*;
#(
    parameter int W          = 4,
    parameter int USE_TOGGLE = EXC_SR
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    output logic [W-1:0] j,
    output logic [W-1:0] k
);

    // Bits already at their target produce J=K=0 in both modes.
    if (USE_TOGGLE == EXC_TOGGLE) begin : g_toggle
        assign j = d ^ q;
        assign k = d ^ q;
    end else begin : g_set_reset
        assign j = d & ~q;
        assign k = ~d & q;
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives one-cycle J/K excitation into a JK bank, waits for settling, verifies Q
// against the target with bounded retries, and reports done/err.
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int W          = 4,
    parameter int USE_TOGGLE = 0,
    parameter int SETTLE_CYC = 1,
    parameter int MAX_RETRY  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tgt_valid,
    input  logic [W-1:0]         tgt_data,
    output logic                 tgt_ready,
    output logic [W-1:0]         j,
    output logic [W-1:0]         k,
    input  logic [W-1:0]         q_fb,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("jk_excitation_driver: SETTLE_CYC must be in 1..15");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_retry
        $error("jk_excitation_driver: MAX_RETRY must be in 0..7");
    end
    if (USE_TOGGLE != EXC_SR && USE_TOGGLE != EXC_TOGGLE) begin : g_bad_mode
        $error("jk_excitation_driver: USE_TOGGLE must be 0 or 1");
    end
    if (W < 1) begin : g_bad_width
        $error("jk_excitation_driver: W must be at least 1");
    end

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRY);

    state_e                 state_q, state_d;
    logic [W-1:0]           target_q, target_d;
    logic [W-1:0]           j_q, j_d, k_q, k_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   accept;
    logic                   match;
    logic [W-1:0]           exc_target;
    logic [W-1:0]           exc_j, exc_k;

    // ready_q is only ever high in IDLE, so no state qualifier is needed here.
    assign accept     = tgt_valid & ready_q;
    assign match      = (q_fb == target_q);
    assign exc_target = (state_q == IDLE) ? tgt_data : target_q;

    jk_excite #(
        .W          (W),
        .USE_TOGGLE (USE_TOGGLE)
    ) u_excite (
        .q (q_fb),
        .d (exc_target),
        .j (exc_j),
        .k (exc_k)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        j_d       = '0;
        k_d       = '0;
        settle_d  = settle_q;
        retry_d   = retry_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = tgt_data;
                    j_d      = exc_j;
                    k_d      = exc_k;
                    retry_d  = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                settle_d = SETTLE_INIT;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SETTLE_W'(1);
                end else if (match) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (retry_q != RETRY_MAX) begin
                    retry_d = retry_q + RETRY_W'(1);
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_d = (state_d == IDLE);

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            j_q       <= '0;
            k_q       <= '0;
            settle_q  <= '0;
            retry_q   <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            j_q       <= j_d;
            k_q       <= k_d;
            settle_q  <= settle_d;
            retry_q   <= retry_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tgt_ready = ready_q;
    assign j         = j_q;
    assign k         = k_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
Controller for a bank of W JK flip-flops: it accepts a target word over a valid/ready handshake and derives the J/K excitation from the bank's current Q. It drives the excitation for exactly one clock, waits for settling, then compares Q feedback against the target. A mismatch is retried a bounded number of times, and the result is reported with a done/err pulse. It sits between register-programming logic and any JK-based state register.

Parameters:
W, 4, width of target word and of the JK bank
USE_TOGGLE, 0, 0: J=d&~q, K=~d&q (set/reset excitation); 1: J=K=d^q (toggle excitation)
SETTLE_CYC, 1, cycles from J/K release to Q comparison (legal range 1..15)
MAX_RETRY, 2, re-drive attempts after a mismatch (legal range 0..7)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
tgt_valid  in  1  target word valid
tgt_data  in  W  desired Q value
tgt_ready  out  1  block can accept a target
j  out  W  J inputs to the JK bank (registered)
k  out  W  K inputs to the JK bank (registered)
q_fb  in  W  Q outputs of the JK bank
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 means Q never matched the target
err_cnt  out  8  saturating count of err completions

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, j=k=0, tgt_ready=0, done=0, err=0, err_cnt=0, retry counter=0, settle counter=0, target_r=0. A reset mid-operation abandons the transaction and reports no done.
- tgt_ready is registered. It goes to 1 on the first clk edge after rst_n releases while in IDLE. It is cleared on the accepting edge and set again on the edge that leaves DONE.
- IDLE: a handshake (tgt_valid&tgt_ready) at edge E0 does the following: latch target_r=tgt_data; load j/k=excite(q_fb,tgt_data); retry=0; go to DRIVE.
- DRIVE: lasts exactly one cycle; j/k are stable for the whole cycle, so the bank samples them at E1. At E1: j=k=0, settle counter=SETTLE_CYC-1, go to SETTLE.
- SETTLE: j=k=0. On each edge the counter decrements. On the edge where the counter is 0, q_fb is compared with target_r:
  - equal: go to DONE with err=0.
  - unequal and retry<MAX_RETRY: retry++; j/k=excite(q_fb,target_r); go to DRIVE.
  - unequal and retry==MAX_RETRY: go to DONE with err=1; err_cnt++ (saturates at 255).
- DONE: lasts one cycle with done=1 and err valid. Next edge: done=0, err=0, tgt_ready=1, go to IDLE.
- Bits where q==d always get J=K=0 in both modes, so there is no spurious toggle.
- Nominal latency with SETTLE_CYC=1 and no retry: accept at E0, J/K at E1, compare at E2, done high in the cycle after E2. That is 3 edges from accept to done.
- If tgt_valid is held during busy, the data is ignored, not queued; the target is sampled only on the handshake.
- An unchanged target (tgt_data==q_fb) still runs DRIVE with zero excitation and completes with err=0.
- Illegal parameter values are caught by an elaboration-time assertion.

Decomposition:
- Package jk_drv_pkg holds:
  - state enum {IDLE, DRIVE, SETTLE, DONE}
  - excitation mode constants EXC_SR=0, EXC_TOGGLE=1
  - ERR_CNT_W=8
- Sub-module jk_excite: purely combinational. Inputs q[W] and d[W], parameter USE_TOGGLE, outputs j[W] and k[W]. The top instantiates it once and registers its output into j/k.

Test Plan:
- Test bench setup: W=4, SETTLE_CYC=1, MAX_RETRY=2, the library JK flip-flop bank as the load.
- Set/reset mode: q=0000, target 1010 -> in DRIVE j=1010, k=0000; q_fb=1010 at compare; done=1, err=0 three edges after accept.
- USE_TOGGLE=1: q=1100, target 0110 -> in DRIVE j=k=1010; final q=0110, err=0.
- Fault injection: force q_fb bit0 stuck at 0, target 0001 -> exactly 3 DRIVE cycles, each with j=0001; then done=1, err=1, err_cnt=1.
- Reset mid-operation: assert rst_n low during the DRIVE cycle -> j=k=0 immediately and no done. After release, tgt_ready=1 after one edge and the next transaction completes normally.
- Handshake rules: hold tgt_valid high with new data across busy -> only the first word is accepted, tgt_ready=0 throughout busy, and the second word is accepted on the edge after DONE.
- Saturation and no-op: 256 forced failures -> err_cnt saturates at 255. A no-op target equal to q -> j=k=0 during DRIVE and err=0.
